// File: rtl/result_bcd_converter_if.sv
// Start/busy/done handshake and data bus between a binary source and the BCD converter.
interface result_bcd_converter_if #(
    parameter int IN_WIDTH = 9,
    parameter int DIGITS   = 3
);
    logic                  start;
    logic [IN_WIDTH-1:0]   data_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start,
        output data_in,
        input  busy,
        input  done,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  data_in,
        output busy,
        output done,
        output bcd_out
    );
endinterface

// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
//   state     | meaning
//   S_IDLE    | waiting for start; bcd_out holds the last result
//   S_CONVERT | one double-dabble step per cycle, IN_WIDTH steps total
//   S_DONE    | bcd_out freshly loaded, done pulse; start may re-trigger
module result_bcd_converter #(
    parameter int IN_WIDTH = 9,
    parameter int DIGITS   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    result_bcd_converter_if.slave bus
);
    localparam int CNT_W  = $clog2(IN_WIDTH + 1);
    localparam int ACC_W  = 4 * DIGITS;

    function automatic longint pow10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint MAX_IN = (longint'(1) << IN_WIDTH) - 1;

    if (IN_WIDTH < 1 || IN_WIDTH > 16) begin : g_width_err
        $fatal(1, "result_bcd_converter: IN_WIDTH must be in 1..16");
    end
    if (pow10(DIGITS) <= MAX_IN) begin : g_digits_err
        $fatal(1, "result_bcd_converter: DIGITS too small for IN_WIDTH");
    end

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

    state_t              state, state_next;
    logic [IN_WIDTH-1:0] bin_shift;
    logic [ACC_W-1:0]    bcd_acc;
    logic [ACC_W-1:0]    acc_adj;
    logic [ACC_W-1:0]    acc_shift;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ACC_W-1:0]    bcd_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                accept;
    logic                last_step;

    assign accept    = bus.start && (state == S_IDLE || state == S_DONE);
    assign last_step = (state == S_CONVERT) && (bit_cnt == CNT_W'(1));

    // Correct every digit before the shift, then bring in the next binary MSB.
    always_comb begin
        acc_adj = bcd_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
        end
        acc_shift = {acc_adj[ACC_W-2:0], bin_shift[IN_WIDTH-1]};
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (bus.start) state_next = S_CONVERT;
            S_CONVERT: if (last_step) state_next = S_DONE;
            S_DONE:    state_next = bus.start ? S_CONVERT : S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            busy_reg <= (state_next == S_CONVERT);
            done_reg <= (state_next == S_DONE);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bin_shift <= '0;
            bcd_acc   <= '0;
            bit_cnt   <= '0;
            bcd_reg   <= '0;
        end else if (accept) begin
            bin_shift <= bus.data_in;
            bcd_acc   <= '0;
            bit_cnt   <= CNT_W'(IN_WIDTH);
        end else if (state == S_CONVERT) begin
            bcd_acc   <= acc_shift;
            bin_shift <= bin_shift << 1;
            bit_cnt   <= bit_cnt - CNT_W'(1);
            if (last_step) bcd_reg <= acc_shift;
        end
    end

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.bcd_out = bcd_reg;
endmodule
